// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
//   Shared definitions for the boot-time program loader: loader state
//   encoding, the default frame start marker and frame-format constants.
//   No ports.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
    localparam int         LEN_W          = 16;  // width of the LEN field
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// word_assembler
//   Collects bytes LSB first into a 32-bit little-endian word. The partial
//   word lives in its own shift register and the finished word in a separate
//   output register, so a new byte can be taken in the same cycle the
//   previous word is presented.
// Ports:
//   clk          : system clock
//   reset        : synchronous, active-high reset
//   i_clear      : synchronous clear at the start of a frame
//   i_byte_valid : i_byte is a data byte this cycle
//   i_byte       : data byte
//   o_last       : the next accepted byte completes a word
//   o_word_valid : one-cycle pulse, o_word holds a finished word
//   o_word       : finished word
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_last,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    localparam logic [1:0] LAST_CNT = 2'(BYTES_PER_WORD - 1);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic        r_valid;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_byte_valid) begin
                if (r_cnt == LAST_CNT) begin
                    // Newest byte is the most significant one.
                    r_word  <= {i_byte, r_shift};
                    r_valid <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_shift <= {i_byte, r_shift[23:8]};
                    r_cnt   <= r_cnt + 2'd1;
                end
            end
        end
    end

    assign o_last       = (r_cnt == LAST_CNT);
    assign o_word_valid = r_valid;
    assign o_word       = r_word;

endmodule

// File: rtl/prog_loader.sv
// prog_loader
//   Parses a framed byte stream (SYNC, LEN_LO, LEN_HI, LEN words LSB first,
//   CSUM), writes the words to memory from ADDR_BASE upward and holds the
//   processor in reset until a complete image with a matching XOR checksum
//   has been stored.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   rx_valid   : one-cycle strobe, rx_byte valid this cycle
//   rx_byte    : received byte
//   reload     : start a new load from DONE or ERR
//   mem_we     : one-cycle write pulse per word
//   mem_addr   : byte address of the write (word aligned)
//   mem_wdata  : word to write
//   cpu_reset  : processor reset, low only in DONE
//   done       : image loaded and verified
//   error      : load failed, sticky until reload or reset
//   dbg_state  : current loader state
// Handshake: the byte input has no back-pressure; every cycle with rx_valid
// high delivers exactly one byte and the loader always accepts it.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 64,
    parameter int          TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        reload,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [2:0]  dbg_state
);

    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_WORDS);
    localparam logic [31:0]      TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      ADDR_INC = 32'(BYTES_PER_WORD);

    state_t             r_state, w_next;
    logic [LEN_W-1:0]   r_len, r_index;
    logic [7:0]         r_csum;
    logic [31:0]        r_addr, r_tmo;
    logic               r_cpu_reset, r_done, r_error;

    logic               w_frame_start, w_timer_on, w_expired, w_last_word;
    logic               w_asm_last, w_word_valid;
    logic [31:0]        w_word;
    logic [LEN_W-1:0]   w_len_full;

    assign w_frame_start = (r_state == ST_IDLE) && rx_valid && (rx_byte == SYNC_BYTE);
    assign w_timer_on    = (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                           (r_state == ST_DATA) || (r_state == ST_CSUM);
    // A byte in the expiry cycle wins over the timeout.
    assign w_expired     = w_timer_on && !rx_valid && (r_tmo == TMO_LAST);
    assign w_len_full    = {rx_byte, r_len[7:0]};
    // r_index already counts every earlier word: their pulses came at least
    // four cycles before the last byte of the current word.
    assign w_last_word   = w_asm_last && (LEN_W'(r_index + 1'b1) == r_len);

    word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_frame_start),
        .i_byte_valid (rx_valid && (r_state == ST_DATA)),
        .i_byte       (rx_byte),
        .o_last       (w_asm_last),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_frame_start) w_next = ST_LEN0;
            ST_LEN0: begin
                if (rx_valid)       w_next = ST_LEN1;
                else if (w_expired) w_next = ST_ERR;
            end
            ST_LEN1: begin
                if (rx_valid) begin
                    if (w_len_full > MAX_LEN)     w_next = ST_ERR;
                    else if (w_len_full == '0)    w_next = ST_CSUM;
                    else                          w_next = ST_DATA;
                end else if (w_expired) begin
                    w_next = ST_ERR;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    if (w_last_word) w_next = ST_CSUM;
                end else if (w_expired) begin
                    w_next = ST_ERR;
                end
            end
            ST_CSUM: begin
                if (rx_valid)       w_next = (rx_byte == r_csum) ? ST_DONE : ST_ERR;
                else if (w_expired) w_next = ST_ERR;
            end
            ST_DONE: if (reload) w_next = ST_IDLE;
            ST_ERR:  if (reload) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_index     <= '0;
            r_csum      <= '0;
            r_addr      <= ADDR_BASE;
            r_tmo       <= '0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_next;
            // Status outputs are decoded from the next state into flops so
            // the processor reset never sees decode glitches.
            r_cpu_reset <= (w_next != ST_DONE);
            r_done      <= (w_next == ST_DONE);
            r_error     <= (w_next == ST_ERR);

            if (!w_timer_on || rx_valid) r_tmo <= '0;
            else                         r_tmo <= r_tmo + 32'd1;

            if (w_frame_start)
                r_csum <= '0;
            else if (rx_valid && ((r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                                  (r_state == ST_DATA)))
                r_csum <= r_csum ^ rx_byte;

            if (rx_valid && (r_state == ST_LEN0)) r_len[7:0] <= rx_byte;
            if (rx_valid && (r_state == ST_LEN1)) r_len      <= w_len_full;

            if (w_frame_start) begin
                r_index <= '0;
                r_addr  <= ADDR_BASE;
            end else if (w_word_valid) begin
                r_index <= r_index + 1'b1;
                r_addr  <= r_addr + ADDR_INC;
            end
        end
    end

    assign mem_we    = w_word_valid;
    assign mem_wdata = w_word;
    assign mem_addr  = r_addr;
    assign cpu_reset = r_cpu_reset;
    assign done      = r_done;
    assign error     = r_error;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        reload;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];

    prog_loader #(
        .ADDR_BASE      (32'h0000_0000),
        .MAX_WORDS      (64),
        .TIMEOUT_CYCLES (16),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // write monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (mem_we === 1'b1) got_q.push_back({mem_addr, mem_wdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        idle(gap);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    // nominal frame without its checksum byte
    task automatic send_nominal_body(input int gap);
        logic [7:0] body [11];
        body = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'hA0, 8'hE3,
                 8'h02, 8'h10, 8'hA0, 8'hE3};
        for (int i = 0; i < 11; i++) send(body[i], gap);
    endtask

    task automatic expect_nominal_writes();
        exp_q.push_back({32'h0000_0000, 32'hE3A0_0001});
        exp_q.push_back({32'h0000_0004, 32'hE3A0_1002});
    endtask

    task automatic check_writes(input string tag);
        logic [63:0] e;
        logic [63:0] g;
        idle(2);
        chk({tag, "_nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 64'hx;
            chk({tag, "_addr"}, g[63:32], e[63:32]);
            chk({tag, "_data"}, g[31:0], e[31:0]);
        end
        got_q.delete();
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        reload   = 1'b0;
        idle(3);

        // reset state
        chk("rst_we",    32'(mem_we), 32'd0);
        chk("rst_addr",  mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_cpu",   32'(cpu_reset), 32'd1);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_err",   32'(error), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;
        idle(1);

        // garbage before sync is ignored
        send(8'h00, 1);
        send(8'hFF, 1);
        send(8'h5A, 1);
        chk("garbage_state", 32'(dbg_state), 32'(ST_IDLE));

        // nominal image with gaps between bytes
        send_nominal_body(1);
        chk("nom_cpu_before", 32'(cpu_reset), 32'd1);
        chk("nom_state_csum", 32'(dbg_state), 32'(ST_CSUM));
        send(8'h11, 0);
        chk("nom_cpu_after", 32'(cpu_reset), 32'd0);
        chk("nom_done",      32'(done), 32'd1);
        chk("nom_err",       32'(error), 32'd0);
        expect_nominal_writes();
        check_writes("nom");

        // bytes ignored in DONE, reload returns to IDLE
        send(8'hA5, 1);
        chk("done_ignore", 32'(done), 32'd1);
        pulse_reload();
        chk("rel_done", 32'(done), 32'd0);
        chk("rel_cpu",  32'(cpu_reset), 32'd1);
        chk("rel_state", 32'(dbg_state), 32'(ST_IDLE));

        // bad checksum
        send_nominal_body(1);
        send(8'h12, 0);
        chk("badcs_err",  32'(error), 32'd1);
        chk("badcs_cpu",  32'(cpu_reset), 32'd1);
        chk("badcs_done", 32'(done), 32'd0);
        expect_nominal_writes();
        check_writes("badcs");
        pulse_reload();
        chk("badcs_rel_err", 32'(error), 32'd0);

        // back-to-back bytes, fresh load after the error
        send_nominal_body(0);
        send(8'h11, 0);
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_cpu",  32'(cpu_reset), 32'd0);
        chk("b2b_err",  32'(error), 32'd0);
        expect_nominal_writes();
        check_writes("b2b");
        pulse_reload();

        // oversize: LEN = 65
        send(8'hA5, 0);
        send(8'h41, 0);
        send(8'h00, 0);
        chk("over_err", 32'(error), 32'd1);
        chk("over_cpu", 32'(cpu_reset), 32'd1);
        check_writes("over");
        pulse_reload();
        chk("over_rel_err", 32'(error), 32'd0);

        // oversize boundary: LEN = 64 is accepted
        send(8'hA5, 0);
        send(8'h40, 0);
        send(8'h00, 0);
        chk("max_state", 32'(dbg_state), 32'(ST_DATA));
        reset = 1'b1;
        idle(1);
        reset = 1'b0;

        // empty frame
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        chk("empty_state", 32'(dbg_state), 32'(ST_CSUM));
        send(8'h00, 0);
        chk("empty_done", 32'(done), 32'd1);
        check_writes("empty");
        pulse_reload();

        // timeout: 16 silent cycles after a byte -> ERR
        send(8'hA5, 0);
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'hAA, 0);
        idle(15);
        chk("tmo_15_err", 32'(error), 32'd0);
        idle(1);
        chk("tmo_16_err",   32'(error), 32'd1);
        chk("tmo_16_state", 32'(dbg_state), 32'(ST_ERR));
        check_writes("tmo");
        pulse_reload();

        // byte exactly in the expiry cycle wins
        send(8'hA5, 0);
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'hAA, 15);
        send(8'hBB, 0);
        chk("tmo_edge_err",   32'(error), 32'd0);
        chk("tmo_edge_state", 32'(dbg_state), 32'(ST_DATA));
        send(8'hCC, 0);
        send(8'hDD, 0);
        send(8'h01, 0);
        chk("tmo_edge_done", 32'(done), 32'd1);
        exp_q.push_back({32'h0000_0000, 32'hDDCC_BBAA});
        check_writes("tmo_edge");
        pulse_reload();

        // reset during DATA after 5 data bytes
        send(8'hA5, 0);
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'hA0, 0);
        send(8'hE3, 0);
        send(8'h02, 0);
        pulse_reload();
        chk("mid_reload_ignored", 32'(dbg_state), 32'(ST_DATA));
        reset = 1'b1;
        idle(1);
        chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("mid_rst_we",    32'(mem_we), 32'd0);
        chk("mid_rst_cpu",   32'(cpu_reset), 32'd1);
        chk("mid_rst_addr",  mem_addr, 32'h0);
        reset = 1'b0;
        exp_q.push_back({32'h0000_0000, 32'hE3A0_0001});
        check_writes("mid");
        send_nominal_body(0);
        send(8'h11, 0);
        chk("mid_reload_done", 32'(done), 32'd1);
        expect_nominal_writes();
        check_writes("mid_reload");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader upstream of the multi-cycle computer.
- Consumes a byte stream from the UART receiver and checks the framing and checksum.
- Assembles little-endian 32-bit words and writes them into the shared instruction/data memory.
- Holds the processor in reset until a complete, valid image is in memory, then releases it so the first fetch sees PC = ADDR_BASE.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte address of the first loaded word.
- MAX_WORDS, 64, memory depth in words; a larger word count is an error.
- TIMEOUT_CYCLES, 1_000_000, maximum idle cycles between bytes once a frame has started.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx_valid  input  1  one-cycle strobe; rx_byte is valid this cycle
- rx_byte  input  8  received byte
- reload  input  1  one-cycle request to start a new load from DONE or ERR
- mem_we  output  1  memory write enable, one-cycle pulse per word
- mem_addr  output  32  byte address of the write, word aligned
- mem_wdata  output  32  word to write
- cpu_reset  output  1  drives the processor's reset input
- done  output  1  image loaded and verified
- error  output  1  load failed; sticky until reload or reset

Behaviour:
- Single clock domain; one synchronous, active-high reset named reset.
- Reset values: state = IDLE, mem_we = 0, mem_addr = ADDR_BASE, mem_wdata = 0, cpu_reset = 1, done = 0, error = 0. Internal word index, byte counter, checksum and timeout counter are all cleared.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then LEN words of 4 bytes each (LSB first), then CSUM.
  - CSUM = XOR of LEN_LO, LEN_HI and every data byte.
- States:
  - IDLE: ignore bytes other than SYNC_BYTE. SYNC_BYTE -> LEN0 and clear the checksum. The timeout is inactive.
  - LEN0: next byte -> LEN[7:0] -> LEN1.
  - LEN1: next byte -> LEN[15:8].
    - If LEN > MAX_WORDS -> ERR.
    - If LEN = 0 -> CSUM.
    - Otherwise -> DATA.
  - DATA: shift bytes into the assembler.
    - On the 4th byte, the next cycle has mem_we = 1, mem_wdata = the assembled word, mem_addr = ADDR_BASE + 4*index.
    - index increments after the write.
    - When index reaches LEN -> CSUM.
  - CSUM: the received byte is compared with the running XOR. Equal -> DONE; different -> ERR.
  - DONE: cpu_reset = 0, done = 1. Bytes are ignored. reload -> IDLE with cpu_reset = 1 and done = 0 in the next cycle.
  - ERR: cpu_reset = 1, error = 1. Bytes are ignored. reload -> IDLE with error = 0.
- cpu_reset = 1 in every state except DONE; it is registered, so there are no glitches.
- Timeout: in LEN0, LEN1, DATA and CSUM, the counter resets on every rx_valid.
  - When it reaches TIMEOUT_CYCLES -> ERR.
  - A byte arriving in the same cycle as expiry takes priority; no error is raised.
- A byte accepted in the same cycle as a mem_we pulse is legal; the assembler is double-buffered, so back-to-back bytes every cycle are supported.
- reload outside DONE/ERR is ignored.
- reset mid-load returns to IDLE immediately. Words already written stay in memory (no rollback), and cpu_reset stays 1.
- mem_addr wraps modulo 2^32 (unreachable with legal MAX_WORDS).

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR);
  - SYNC_BYTE default;
  - the frame-format constants (LEN field width 16, bytes per word 4).
- One sub-module, word_assembler: 4-byte little-endian shift register with a byte counter and a word_valid pulse. It is cleared by reset or by the frame start.

Test Plan:
- Nominal 2-word image: A5 02 00 01 00 A0 E3 02 10 A0 E3 11 -> mem_we pulses at addr 0x0 with 0xE3A00001 and addr 0x4 with 0xE3A01002. Then done = 1, cpu_reset falls one cycle after the CSUM byte, error = 0.
- Bad checksum: same frame with CSUM 0x12 -> both writes occur, then error = 1, cpu_reset stays 1. reload -> error = 0 and a fresh load succeeds.
- Oversize and empty frames:
  - LEN = 65 (A5 41 00) -> ERR with no mem_we.
  - LEN = 0 (A5 00 00 00) -> DONE with no writes.
- Timeout: send A5 01 00 AA, then go silent for TIMEOUT_CYCLES (overridden to 16) -> ERR at cycle 16. A repeat run where a byte arrives exactly at cycle 16 shows no error.
- Garbage and reset mid-load:
  - Bytes 00 FF 5A before SYNC are ignored.
  - Asserting reset during DATA after 5 bytes -> IDLE, mem_we = 0, cpu_reset = 1, index 0. The next full frame loads from ADDR_BASE.
- Back-to-back bytes, rx_valid high for 12 consecutive cycles with the nominal frame -> identical writes and result to the first scenario.
